audio_recorder: RTL and testbench
=================================

Name: audio_recorder

Overview:
- Consumes the codec ADC path (read_ready / read / readdata_left / readdata_right) and mixes left and right to mono.
- On request, stores decimated mono samples into on-chip RAM.
- On a later request, replays the stored samples through the codec DAC write handshake.
- Sits beside the playback/track-select logic under the audio top level. Keyboard control supplies the record and play requests.

Parameters:
- DATA_W, 24, codec sample width
- ADDR_W, 14, RAM address width; depth 2**ADDR_W samples
- DECIM, 2, keep 1 of every DECIM accepted ADC samples; each stored sample is replayed DECIM times; legal range 1..8

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- read_ready  in  1  codec has an ADC sample pair
- readdata_left  in  DATA_W  ADC left, signed
- readdata_right  in  DATA_W  ADC right, signed
- read  out  1  consume ADC sample pair
- write_ready  in  1  codec can accept a DAC sample
- write  out  1  push DAC sample
- playData  out  DATA_W  DAC sample, drives writedata_left and writedata_right
- recordRequest  in  1  one-cycle pulse: start or stop recording
- playRequest  in  1  one-cycle pulse: start or abort playback
- recording  out  1  high in RECORD
- playing  out  1  high in PLAY
- recLength  out  ADDR_W+1  stored sample count
- recDone  out  1  one-cycle pulse when RECORD ends
- playDone  out  1  one-cycle pulse when PLAY ends

Behaviour:
- Clock and reset: one clock, CLOCK_50. reset is synchronous and active-high.
- Reset values: state IDLE; recording=0, playing=0, recLength=0, recDone=0, playDone=0, playData=0, decimation counter 0, address counters 0. RAM contents are not cleared.
- read = read_ready in every state (combinational). The ADC FIFO is always drained.
- write = write_ready in every state. playData is 0 outside PLAY, so silence is written.
- Mono mix: (L>>>1)+(R>>>1), arithmetic shift, DATA_W result, no overflow possible.
- FSM states: IDLE, RECORD, PLAY, PFETCH (one-cycle RAM prefetch).
- IDLE:
  - recordRequest -> RECORD; clear wrAddr and the decimation counter.
  - else playRequest -> PFETCH (record wins on a simultaneous pulse).
  - playRequest with recLength=0 -> playDone pulse next cycle, stay IDLE.
- RECORD:
  - On each read&&read_ready: if decimation counter==0, write the mono sample to RAM[wrAddr] and increment wrAddr.
  - Decimation counter wraps modulo DECIM.
  - Exit to IDLE when recordRequest pulses or when wrAddr reaches 2**ADDR_W (full).
  - On exit: recLength<=wrAddr (the exit cycle's accepted sample is included), recDone pulse for 1 cycle.
  - playRequest is ignored in RECORD.
- PFETCH: issue RAM read of rdAddr=0 (synchronous RAM, 1-cycle latency), then -> PLAY with playData loaded.
- PLAY:
  - On each write&&write_ready: increment the repeat counter.
  - When the repeat counter wraps at DECIM, advance rdAddr and present the next sample. The prefetch keeps playData valid on the cycle after the wrap, with no bubble, given ≥2 cycles between write_ready pulses.
  - After the last sample's DECIM-th write: playData<=0, playDone pulse, -> IDLE.
  - playRequest in PLAY aborts: -> IDLE, playData<=0, playDone pulse.
  - recordRequest in PLAY is ignored.
- Reset mid-RECORD: recLength returns to 0; the partial recording is discarded.

Optional Feature:
- Macro: AUDIO_REC_LOOP_EN.
- Defined: at end of recording, PLAY restarts at rdAddr=0 with no silence gap. Only playRequest exits; playDone is pulsed only on that abort.
- Undefined: single-shot playback as described in Behaviour.

Decomposition:
- audio_rec_pkg:
  - state enum (IDLE, RECORD, PFETCH, PLAY)
  - DATA_W default constant
  - mono_mix function
- Sub-module audio_rec_ram: simple dual-port synchronous RAM, one write port and one read port, registered read, infers block RAM. Ports: clk, we, waddr, wdata, raddr, rdata.

Test Plan:
- Reset, then read_ready pulsed every 4 cycles -> read mirrors read_ready; write mirrors write_ready; playData=0; recording=0.
- DECIM=2: recordRequest, then 10 ADC pairs L=1000, R=2000, then recordRequest -> recDone pulse; recLength=5; RAM[0..4]=1500.
- Play that recording with write_ready every 4 cycles -> exactly 10 writes of 1500, then playData=0; one playDone pulse; playing=0.
- ADDR_W=4, continuous recording without stop -> auto-stop at 16 stored samples; recLength=16; recDone pulse.
- recordRequest and playRequest in the same cycle in IDLE -> RECORD entered. playRequest with recLength=0 -> playDone next cycle, no PLAY.
- playRequest mid-playback -> IDLE next cycle; playDone pulse; playData=0. With AUDIO_REC_LOOP_EN, a 3-sample clip replays as 0,1,2,0,1,2… until playRequest.

Source files
------------

// File: rtl/audio_rec_pkg.sv
// Shared constants, FSM state encodings and the stereo-to-mono mix for the audio recorder.
package audio_rec_pkg;

   localparam int AREC_DATA_W = 24;
   localparam int MIX_W       = 32;
   localparam int CNT_W       = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_RECORD = 2'd1;
   localparam state_t ST_PFETCH = 2'd2;
   localparam state_t ST_PLAY   = 2'd3;

   // Halving each channel before the add keeps the sum inside the original sample range.
   function automatic logic signed [MIX_W-1:0] mono_mix(input logic signed [MIX_W-1:0] l,
                                                        input logic signed [MIX_W-1:0] r);
      return (l >>> 1) + (r >>> 1);
   endfunction

endpackage

// File: rtl/audio_rec_if.sv
// Codec ADC/DAC handshake bundle; the recorder is the master, the codec the slave.
interface audio_rec_if
   import audio_rec_pkg::*;
#(
   parameter int DATA_W = AREC_DATA_W
);
   logic                     read_ready;
   logic signed [DATA_W-1:0] readdata_left;
   logic signed [DATA_W-1:0] readdata_right;
   logic                     read;
   logic                     write_ready;
   logic                     write;
   logic signed [DATA_W-1:0] playData;

   modport master (
      input  read_ready, readdata_left, readdata_right, write_ready,
      output read, write, playData
   );

   modport slave (
      output read_ready, readdata_left, readdata_right, write_ready,
      input  read, write, playData
   );
endinterface

// File: rtl/audio_rec_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
module audio_rec_ram #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/audio_recorder.sv
// Records decimated mono ADC samples into RAM and replays them through the DAC handshake.
// Define AUDIO_REC_LOOP_EN to make playback loop until aborted by playRequest.
module audio_recorder
   import audio_rec_pkg::*;
#(
   parameter int DATA_W = AREC_DATA_W,
   parameter int ADDR_W = 14,
   parameter int DECIM  = 2
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   audio_rec_if.master   codec,
   input  logic          recordRequest,
   input  logic          playRequest,
   output logic          recording,
   output logic          playing,
   output logic [ADDR_W:0] recLength,
   output logic          recDone,
   output logic          playDone
);
   localparam logic [ADDR_W:0] FULL     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

   state_t                   state_q, state_d;
   logic [ADDR_W:0]          wr_addr_q, wr_addr_d;
   logic [ADDR_W:0]          rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]         dec_q, dec_d;
   logic [CNT_W-1:0]         rep_q, rep_d;
   logic [ADDR_W:0]          rec_len_q, rec_len_d;
   logic                     rec_done_q, rec_done_d;
   logic                     play_done_q, play_done_d;
   logic signed [DATA_W-1:0] play_data_q, play_data_d;

   logic                     ram_we;
   logic [ADDR_W-1:0]        ram_raddr;
   logic [DATA_W-1:0]        ram_rdata;
   logic signed [DATA_W-1:0] mono;
   logic [ADDR_W:0]          rd_next;
   logic                     rd_last;

   assign mono    = DATA_W'(mono_mix(MIX_W'(codec.readdata_left), MIX_W'(codec.readdata_right)));
   assign rd_next = rd_addr_q + 1'b1;
   assign rd_last = (rd_next == rec_len_q);

   // The read port always looks one sample ahead so a repeat-counter wrap never waits on RAM.
   always_comb begin
      ram_raddr = '0;
      case (state_q)
         ST_PFETCH: ram_raddr = ADDR_W'(1);
         ST_PLAY:   ram_raddr = rd_last ? '0 : rd_next[ADDR_W-1:0];
         default:   ram_raddr = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      dec_d       = dec_q;
      rep_d       = rep_q;
      rec_len_d   = rec_len_q;
      rec_done_d  = 1'b0;
      play_done_d = 1'b0;
      play_data_d = play_data_q;
      ram_we      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (recordRequest) begin
               state_d   = ST_RECORD;
               wr_addr_d = '0;
               dec_d     = '0;
            end else if (playRequest) begin
               if (rec_len_q == '0) begin
                  play_done_d = 1'b1;
               end else begin
                  state_d   = ST_PFETCH;
                  rd_addr_d = '0;
                  rep_d     = '0;
               end
            end
         end
         ST_RECORD: begin
            if (codec.read_ready) begin
               dec_d = (dec_q == CNT_LAST) ? '0 : dec_q + 1'b1;
               if (dec_q == '0) begin
                  ram_we    = 1'b1;
                  wr_addr_d = wr_addr_q + 1'b1;
               end
            end
            if (recordRequest || (wr_addr_d == FULL)) begin
               state_d    = ST_IDLE;
               rec_len_d  = wr_addr_d;
               rec_done_d = 1'b1;
            end
         end
         ST_PFETCH: begin
            play_data_d = ram_rdata;
            state_d     = ST_PLAY;
         end
         ST_PLAY: begin
            if (playRequest) begin
               state_d     = ST_IDLE;
               play_data_d = '0;
               play_done_d = 1'b1;
            end else if (codec.write_ready) begin
               if (rep_q == CNT_LAST) begin
                  rep_d = '0;
                  if (rd_last) begin
`ifdef AUDIO_REC_LOOP_EN
                     rd_addr_d   = '0;
                     play_data_d = ram_rdata;
`else
                     state_d     = ST_IDLE;
                     play_data_d = '0;
                     play_done_d = 1'b1;
`endif
                  end else begin
                     rd_addr_d   = rd_next;
                     play_data_d = ram_rdata;
                  end
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_addr_q   <= '0;
         rd_addr_q   <= '0;
         dec_q       <= '0;
         rep_q       <= '0;
         rec_len_q   <= '0;
         rec_done_q  <= 1'b0;
         play_done_q <= 1'b0;
         play_data_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         dec_q       <= dec_d;
         rep_q       <= rep_d;
         rec_len_q   <= rec_len_d;
         rec_done_q  <= rec_done_d;
         play_done_q <= play_done_d;
         play_data_q <= play_data_d;
      end
   end

   audio_rec_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (CLOCK_50),
      .we   (ram_we),
      .waddr(wr_addr_q[ADDR_W-1:0]),
      .wdata(mono),
      .raddr(ram_raddr),
      .rdata(ram_rdata)
   );

   assign codec.read     = codec.read_ready;
   assign codec.write    = codec.write_ready;
   assign codec.playData = play_data_q;
   assign recording      = (state_q == ST_RECORD);
   assign playing        = (state_q == ST_PLAY);
   assign recLength      = rec_len_q;
   assign recDone        = rec_done_q;
   assign playDone       = play_done_q;
endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder with a small RAM (ADDR_W=4) and DECIM=2.
module tb_audio_recorder;
   localparam int DATA_W = 24;
   localparam int ADDR_W = 4;
   localparam int DECIM  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic recordRequest = 1'b0;
   logic playRequest = 1'b0;
   logic recording, playing, recDone, playDone;
   logic [ADDR_W:0] recLength;

   int checks = 0;
   int failures = 0;
   int exp_samp [16];

   audio_rec_if #(.DATA_W(DATA_W)) codec ();

   audio_recorder #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DECIM (DECIM)
   ) u_dut (
      .CLOCK_50     (clk),
      .reset        (rst),
      .codec        (codec),
      .recordRequest(recordRequest),
      .playRequest  (playRequest),
      .recording    (recording),
      .playing      (playing),
      .recLength    (recLength),
      .recDone      (recDone),
      .playDone     (playDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int bmix(input int l, input int r);
      return (l >>> 1) + (r >>> 1);
   endfunction

   task automatic pulse_rec();
      @(negedge clk) recordRequest = 1'b1;
      @(negedge clk) recordRequest = 1'b0;
   endtask

   task automatic pulse_play();
      @(negedge clk) playRequest = 1'b1;
      @(negedge clk) playRequest = 1'b0;
   endtask

   // Plays the current recording; abort_after >= 0 aborts once that many writes happened.
   task automatic play_run(input string tag, input int nsamp, input int abort_after);
      int writes = 0;
      int dones = 0;
      int cyc = 0;
      bit aborted = 0;
      pulse_play();
      while (cyc < 400) begin
         @(negedge clk);
         codec.write_ready = 1'b0;
         if (playDone) dones++;
         if (dones > 0 && !playing) break;
         if (playing && abort_after >= 0 && writes == abort_after) begin
            pulse_rec();
            chk({tag, "_rec_ignored"}, {31'b0, recording}, 32'd0);
            chk({tag, "_still_playing"}, {31'b0, playing}, 32'd1);
            pulse_play();
            chk({tag, "_abort_playing"}, {31'b0, playing}, 32'd0);
            chk({tag, "_abort_done"}, {31'b0, playDone}, 32'd1);
            chk({tag, "_abort_data"}, 32'(codec.playData), 32'd0);
            aborted = 1;
            break;
         end
         if (playing && (cyc % 4 == 0)) begin
            codec.write_ready = 1'b1;
            #1;
            chk({tag, "_write"}, {31'b0, codec.write}, 32'd1);
            if (writes < nsamp * DECIM)
               chk({tag, "_data"}, 32'(codec.playData), 32'(exp_samp[writes / DECIM]));
            writes++;
         end
         cyc++;
      end
      codec.write_ready = 1'b0;
      chk({tag, "_in_time"}, {31'b0, cyc < 400}, 32'd1);
      if (!aborted) begin
         chk({tag, "_writes"}, 32'(writes), 32'(nsamp * DECIM));
         chk({tag, "_dones"}, 32'(dones), 32'd1);
         chk({tag, "_end_data"}, 32'(codec.playData), 32'd0);
         chk({tag, "_end_playing"}, {31'b0, playing}, 32'd0);
         @(negedge clk);
         chk({tag, "_done_width"}, {31'b0, playDone}, 32'd0);
      end
   endtask

   initial begin
      int k;
      codec.read_ready     = 1'b0;
      codec.write_ready    = 1'b0;
      codec.readdata_left  = '0;
      codec.readdata_right = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      chk("rst_recording", {31'b0, recording}, 32'd0);
      chk("rst_playing", {31'b0, playing}, 32'd0);
      chk("rst_recLength", 32'(recLength), 32'd0);
      chk("rst_recDone", {31'b0, recDone}, 32'd0);
      chk("rst_playDone", {31'b0, playDone}, 32'd0);
      chk("rst_playData", 32'(codec.playData), 32'd0);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         codec.read_ready  = (i % 4 == 0);
         codec.write_ready = (i % 4 == 2);
         #1;
         chk("idle_read", {31'b0, codec.read}, {31'b0, (i % 4 == 0)});
         chk("idle_write", {31'b0, codec.write}, {31'b0, (i % 4 == 2)});
         chk("idle_silence", 32'(codec.playData), 32'd0);
      end
      @(negedge clk);
      codec.read_ready  = 1'b0;
      codec.write_ready = 1'b0;
      chk("idle_recording", {31'b0, recording}, 32'd0);

      // Empty recording: playDone pulse only, PLAY never entered.
      pulse_play();
      chk("empty_playDone", {31'b0, playDone}, 32'd1);
      chk("empty_playing", {31'b0, playing}, 32'd0);
      @(negedge clk);
      chk("empty_playDone_off", {31'b0, playDone}, 32'd0);
      chk("empty_playing2", {31'b0, playing}, 32'd0);

      // Simultaneous requests: record wins.
      @(negedge clk);
      recordRequest = 1'b1;
      playRequest   = 1'b1;
      @(negedge clk);
      recordRequest = 1'b0;
      playRequest   = 1'b0;
      chk("both_recording", {31'b0, recording}, 32'd1);
      chk("both_playing", {31'b0, playing}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         codec.read_ready     = 1'b1;
         codec.readdata_left  = 24'sd1000;
         codec.readdata_right = 24'sd2000;
         @(negedge clk);
         codec.read_ready = 1'b0;
      end
      pulse_rec();
      chk("rec1_recDone", {31'b0, recDone}, 32'd1);
      chk("rec1_recording", {31'b0, recording}, 32'd0);
      chk("rec1_recLength", 32'(recLength), 32'd5);
      @(negedge clk);
      chk("rec1_recDone_off", {31'b0, recDone}, 32'd0);

      for (int j = 0; j < 16; j++) exp_samp[j] = 1500;
      play_run("play1", 5, -1);

      // Continuous capture until the 16-entry RAM fills.
      pulse_rec();
      k = 0;
      while (k < 100) begin
         @(negedge clk);
         if (recDone) break;
         codec.read_ready     = 1'b1;
         codec.readdata_left  = 24'(300 * k - 4001);
         codec.readdata_right = 24'(2999 - 200 * k);
         k++;
      end
      codec.read_ready = 1'b0;
      chk("full_recDone", {31'b0, recDone}, 32'd1);
      chk("full_recLength", 32'(recLength), 32'd16);
      chk("full_recording", {31'b0, recording}, 32'd0);
      chk("full_accepted", 32'(k), 32'd31);

      for (int j = 0; j < 16; j++) exp_samp[j] = bmix(300 * (2 * j) - 4001, 2999 - 200 * (2 * j));
      play_run("play2", 16, -1);
      play_run("abort", 16, 3);

      // Reset during a recording throws the clip away.
      pulse_rec();
      chk("rst_mid_recording", {31'b0, recording}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         codec.read_ready = 1'b1;
      end
      @(negedge clk);
      codec.read_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_recLength", 32'(recLength), 32'd0);
      chk("rst_mid_state", {31'b0, recording}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
